// File: rtl/display_scheduler.sv
// Selects one of four 16-bit debug taps for the seven-segment data bus, advancing on a
// debounced button or an auto-rotate timer. Optional macro DISPLAY_SRC_TAG_EN shows the source index on the top digit.
module display_scheduler #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ROTATE_CYCLES   = 1024
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        btn_next,
    input  logic        auto_en,
    input  logic [15:0] src0,
    input  logic [15:0] src1,
    input  logic [15:0] src2,
    input  logic [15:0] src3,
    output logic [15:0] disp_data,
    output logic [1:0]  src_sel,
    output logic        sel_changed
);

    localparam logic [15:0] DMAX = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [23:0] RMAX = 24'(ROTATE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    state_t      state_q, state_d;
    logic        sync1_q, b_s_q;
    logic [15:0] dcnt_q, dcnt_d;
    logic [23:0] rcnt_q, rcnt_d;
    logic        step_q, step_d;
    logic [1:0]  src_sel_q, src_sel_d;
    logic        sel_changed_q, sel_changed_d;
    logic [15:0] disp_q, disp_d;
    logic        adv_d, rot_d;
    logic [15:0] cur_src;

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        adv_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (b_s_q) begin
                    state_d = PRESS_WAIT;
                    dcnt_d  = 16'd1;
                end
            end
            PRESS_WAIT: begin
                if (!b_s_q) begin
                    state_d = IDLE;
                    dcnt_d  = 16'd0;
                end else if (dcnt_q == DMAX) begin
                    state_d = HELD;
                    adv_d   = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 16'd1;
                end
            end
            HELD: begin
                // Holding never repeats; only a debounced release re-arms the press path.
                if (!b_s_q) begin
                    state_d = RELEASE_WAIT;
                    dcnt_d  = 16'd1;
                end
            end
            RELEASE_WAIT: begin
                if (b_s_q) begin
                    state_d = HELD;
                    dcnt_d  = 16'd0;
                end else if (dcnt_q == DMAX) begin
                    state_d = IDLE;
                end else begin
                    dcnt_d = dcnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                dcnt_d  = 16'd0;
            end
        endcase
    end

    always_comb begin
        rot_d  = 1'b0;
        rcnt_d = rcnt_q;
        if (!auto_en) begin
            rcnt_d = 24'd0;
        end else if (rcnt_q == RMAX) begin
            rcnt_d = 24'd0;
            rot_d  = 1'b1;
        end else begin
            rcnt_d = rcnt_q + 24'd1;
        end
        // A button advance restarts the rotate period; a coinciding rotate merges into one step.
        if (adv_d) begin
            rcnt_d = 24'd0;
        end
        step_d        = adv_d | rot_d;
        src_sel_d     = step_q ? src_sel_q + 2'd1 : src_sel_q;
        sel_changed_d = step_q;
    end

    always_comb begin
        case (src_sel_q)
            2'd0:    cur_src = src0;
            2'd1:    cur_src = src1;
            2'd2:    cur_src = src2;
            default: cur_src = src3;
        endcase
`ifdef DISPLAY_SRC_TAG_EN
        disp_d = {2'b00, src_sel_q, cur_src[11:0]};
`else
        disp_d = cur_src;
`endif
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1_q       <= 1'b0;
            b_s_q         <= 1'b0;
            state_q       <= IDLE;
            dcnt_q        <= 16'd0;
            rcnt_q        <= 24'd0;
            step_q        <= 1'b0;
            src_sel_q     <= 2'd0;
            sel_changed_q <= 1'b0;
            disp_q        <= 16'd0;
        end else begin
            sync1_q       <= btn_next;
            b_s_q         <= sync1_q;
            state_q       <= state_d;
            dcnt_q        <= dcnt_d;
            rcnt_q        <= rcnt_d;
            step_q        <= step_d;
            src_sel_q     <= src_sel_d;
            sel_changed_q <= sel_changed_d;
            disp_q        <= disp_d;
        end
    end

    assign disp_data   = disp_q;
    assign src_sel     = src_sel_q;
    assign sel_changed = sel_changed_q;

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Selects which of four 16-bit debug sources drives the 4-digit seven-segment display data bus (disp_data into displayReg).
- Sources are, by convention, PC, current instruction, register-file read data and ALU result.
- Source selection advances on a debounced push-button, or rotates automatically on a programmable period.
- Sits between CPU debug taps and displayReg on the board top level, in the fast clk domain (not the 190 Hz scan clock).

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive synchronized-stable samples needed to accept a button press or release; legal range 2..65535.
- ROTATE_CYCLES, 1024: clk cycles per source in auto-rotate mode; legal range 2..2^24.

Ports:
- clk  input  1  system clock; all state on rising edge.
- clr  input  1  asynchronous, active-high reset.
- btn_next  input  1  raw, bouncy, asynchronous push-button; high = pressed.
- auto_en  input  1  level; 1 = auto-rotate mode; synchronous to clk.
- src0  input  16  debug source 0 (PC).
- src1  input  16  debug source 1 (instruction).
- src2  input  16  debug source 2 (register read data).
- src3  input  16  debug source 3 (ALU result).
- disp_data  output  16  registered selected source, to displayReg.
- src_sel  output  2  current source index.
- sel_changed  output  1  one-cycle pulse on the edge src_sel changes.

Behaviour:
- Reset (clr=1, async):
  - src_sel=0, disp_data=0, sel_changed=0.
  - Sync flops=0, debounce counter=0, rotate counter=0, FSM=IDLE.
  - Release of clr restarts from that state; a press in progress is discarded.
- Input sync: btn_next passes through a 2-flop synchronizer (b_s); only b_s feeds the FSM.
- Debounce FSM, with counter dcnt:
  - IDLE: b_s=1 → PRESS_WAIT, dcnt=1. Otherwise stay.
  - PRESS_WAIT: if b_s=0 → IDLE, dcnt=0. Else if dcnt==DEBOUNCE_CYCLES-1 → HELD and assert internal adv for that edge. Else dcnt+1.
  - HELD: b_s=0 → RELEASE_WAIT, dcnt=1. Holding the button never repeats.
  - RELEASE_WAIT: if b_s=1 → HELD, dcnt=0. Else if dcnt==DEBOUNCE_CYCLES-1 → IDLE. Else dcnt+1.
  - Net timing: src_sel increments exactly DEBOUNCE_CYCLES+2 edges after the first edge that samples btn_next high, provided btn_next stays high throughout.
- Rotation (auto_en=1):
  - rcnt counts 0..ROTATE_CYCLES-1. On the edge where rcnt==ROTATE_CYCLES-1, rcnt→0 and a rotate advance occurs.
  - auto_en=0: rcnt held at 0.
  - The first rotate advance occurs ROTATE_CYCLES edges after the first edge sampling auto_en=1.
- Advance arbitration:
  - Button adv on any edge: src_sel+1 and rcnt→0.
  - Button adv and rotate advance on the same edge: src_sel advances by exactly 1, rcnt→0.
  - src_sel wraps 3→0 (2-bit modulo).
  - sel_changed=1 on the edge src_sel is updated, else 0.
- Data path:
  - Every edge, disp_data <= src[src_sel] using the pre-edge src_sel value.
  - So disp_data follows the new source one edge after src_sel changes, and otherwise tracks live source changes with 1-cycle latency.
- auto_en toggled mid-count: clearing rcnt takes effect on the next edge; the button path is unaffected.

Optional Feature:
- Macro: DISPLAY_SRC_TAG_EN.
- Defined: disp_data[15:12] <= {2'b00, src_sel(pre-edge)} and disp_data[11:0] <= src[src_sel][11:0], so the leftmost digit shows the source number 0..3.
- Undefined: disp_data carries all 16 source bits.
- Reset value 0 in both builds.

Test Plan (bench uses DEBOUNCE_CYCLES=4, ROTATE_CYCLES=8, src0=16'h1a9b, src1=16'h2c3d, src2=16'h0000, src3=16'hffff, DISPLAY_SRC_TAG_EN undefined unless stated):
- Reset: hold clr=1 3 cycles, then release → src_sel=0, sel_changed=0; disp_data=16'h1a9b one edge after release.
- Clean press: btn_next 0→1 sampled at edge k, held 20 cycles → src_sel=1 at edge k+6, sel_changed pulses only at k+6, disp_data=16'h2c3d at k+7; no further change while held.
- Bounce rejection: btn_next high 3 cycles, low 1, high 3, low (all < 4 stable) → src_sel stays 0, sel_changed never asserted.
- Wrap and release debounce: four clean presses, each followed by ≥6 low cycles → src_sel 1,2,3,0; disp_data ends at 16'h1a9b. A release glitch of 2 low cycles mid-hold gives no extra advance.
- Auto-rotate plus collision: auto_en=1 from edge j → src_sel increments at j+8, j+16. A press timed so its adv lands on edge j+24 (rotate edge) → single increment, next rotate at j+32.
- Tag build (DISPLAY_SRC_TAG_EN defined): src_sel=3 with src3=16'hffff → disp_data=16'h3fff; with src_sel=0 → 16'h0a9b.
